// File: rtl/fifo_rd_unpack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_unpack_pkg
//  Purpose  : Shared widths, line geometry defaults, data typedefs and a
//             pixel-counter helper for the 32->16 FIFO read-side unpacker.
//  Ports    : none (package)
//  Config   : FIFO_RD_UNPACK_HI_FIRST_EN (consumed by fifo_rd_unpack_32to16)
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_unpack_pkg;

    localparam int RD_DATA_WIDTH = 32;
    localparam int PIX_WIDTH     = 16;
    localparam int LINE_PIXELS   = 1920;
    localparam int PIX_CNT_W     = 11;

    typedef logic [PIX_WIDTH-1:0]     pix_t;
    typedef logic [RD_DATA_WIDTH-1:0] word_t;

    // Pixel index advance with wrap at the last pixel of the line.
    function automatic logic [PIX_CNT_W-1:0] pix_cnt_inc(
        input logic [PIX_CNT_W-1:0] cnt,
        input logic [PIX_CNT_W-1:0] last_idx
    );
        if (cnt == last_idx) begin
            return '0;
        end
        return cnt + 1'b1;
    endfunction

endpackage : fifo_rd_unpack_pkg
`default_nettype wire

// File: rtl/fifo_rd_unpack_32to16_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_unpack_32to16_if
//  Purpose  : Bundles the FIFO read port and the downstream pixel stream of
//             the 32->16 unpacker.
//  Modports : master - the unpacker (drives fifo_rd_en and the pixel stream)
//             slave  - the environment (FIFO model / consumer)
//  Signals  : fifo_rd_en, fifo_rd_data, fifo_rd_empty,
//             m_data, m_valid, m_ready, m_last, pix_cnt
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_unpack_32to16_if #(
    parameter int RD_DATA_WIDTH = 32,
    parameter int PIX_WIDTH     = 16,
    parameter int PIX_CNT_W     = 11
);
    logic                     fifo_rd_en;
    logic [RD_DATA_WIDTH-1:0] fifo_rd_data;
    logic                     fifo_rd_empty;
    logic [PIX_WIDTH-1:0]     m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;
    logic [PIX_CNT_W-1:0]     pix_cnt;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last,
        output pix_cnt
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last,
        input  pix_cnt
    );
endinterface : fifo_rd_unpack_32to16_if
`default_nettype wire

// File: rtl/fifo_rd_word_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_word_buf
//  Purpose  : Two-entry, first-in-first-out word buffer between the FIFO read
//             port and the pixel splitter. Push and pop on the same edge keep
//             occupancy constant and preserve order.
//  Ports    : clk, rst_n (async, active low)
//             push / push_data : write one word
//             pop              : retire the head word
//             occ              : entries held (0..2)
//             head             : oldest word (meaningful while occ != 0)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_word_buf #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [1:0]       occ,
    output logic      [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        // Guards keep the buffer self-consistent even if a caller misbehaves;
        // a push into a full buffer is only legal when the head leaves too.
        w_pop_ok  = pop && (occ_q != 2'd0);
        w_push_ok = push && ((occ_q != 2'd2) || w_pop_ok);

        if (w_push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({w_push_ok, w_pop_ok})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule : fifo_rd_word_buf
`default_nettype wire

// File: rtl/fifo_rd_unpack_32to16.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_unpack_32to16
//  Purpose  : FIFO read-side drain engine. Pops 32-bit words from a FIFO with
//             one-cycle read latency, splits each into two 16-bit pixels and
//             presents them on a valid/ready stream with an end-of-line
//             marker and an in-line pixel index.
//  Ports    : clk        - FIFO read clock
//             rst_n      - asynchronous active-low reset
//             bus.master - fifo_rd_en (comb), fifo_rd_data, fifo_rd_empty,
//                          m_data, m_valid, m_ready, m_last, pix_cnt
//  Config   : FIFO_RD_UNPACK_HI_FIRST_EN defined -> bits [31:16] go out first;
//             undefined (default) -> bits [15:0] go out first.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_unpack_32to16
    import fifo_rd_unpack_pkg::*;
#(
    parameter int RD_DATA_WIDTH = 32,
    parameter int PIX_WIDTH     = 16,
    parameter int LINE_PIXELS   = 1920
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    fifo_rd_unpack_32to16_if.master    bus
);

    localparam logic [PIX_CNT_W-1:0] LAST_IDX = PIX_CNT_W'(LINE_PIXELS - 1);

    logic                     infl_q, infl_d;
    logic                     half_sel_q, half_sel_d;
    logic [PIX_CNT_W-1:0]     pix_cnt_q, pix_cnt_d;

    logic [1:0]               w_occ;
    logic [RD_DATA_WIDTH-1:0] w_head;
    logic                     w_rd_en;
    logic                     w_valid;
    logic                     w_beat;
    logic                     w_pop;
    logic [PIX_WIDTH-1:0]     w_first_pix;
    logic [PIX_WIDTH-1:0]     w_second_pix;
    logic [PIX_WIDTH-1:0]     w_sel_pix;

    // ------------------------------------------------------------------
    // Word buffer; the word requested last cycle lands on this edge.
    // ------------------------------------------------------------------
    fifo_rd_word_buf #(
        .WIDTH (RD_DATA_WIDTH)
    ) u_word_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_q),
        .push_data (bus.fifo_rd_data),
        .pop       (w_pop),
        .occ       (w_occ),
        .head      (w_head)
    );

    // ------------------------------------------------------------------
    // Half ordering within a word.
    // ------------------------------------------------------------------
`ifdef FIFO_RD_UNPACK_HI_FIRST_EN
    assign w_first_pix  = w_head[RD_DATA_WIDTH-1:PIX_WIDTH];
    assign w_second_pix = w_head[PIX_WIDTH-1:0];
`else
    assign w_first_pix  = w_head[PIX_WIDTH-1:0];
    assign w_second_pix = w_head[RD_DATA_WIDTH-1:PIX_WIDTH];
`endif

    // ------------------------------------------------------------------
    // Read issue, beat tracking and pixel counting.
    // ------------------------------------------------------------------
    always_comb begin
        // Count the in-flight read against the buffer so a returning word
        // always has a slot; rst_n gates the strobe while reset is held.
        w_rd_en = rst_n && !bus.fifo_rd_empty &&
                  (({1'b0, w_occ} + {2'b00, infl_q}) < 3'd2);
        infl_d  = w_rd_en;

        w_valid = (w_occ != 2'd0);
        w_beat  = w_valid && bus.m_ready;
        // The head word retires only once its second half has gone out.
        w_pop   = w_beat && half_sel_q;

        half_sel_d = half_sel_q ^ w_beat;
        pix_cnt_d  = pix_cnt_q;
        if (w_beat) begin
            pix_cnt_d = pix_cnt_inc(pix_cnt_q, LAST_IDX);
        end

        w_sel_pix = half_sel_q ? w_second_pix : w_first_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q     <= 1'b0;
            half_sel_q <= 1'b0;
            pix_cnt_q  <= '0;
        end else begin
            infl_q     <= infl_d;
            half_sel_q <= half_sel_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    // Data is forced to zero while nothing is valid so the idle and reset
    // output values are well defined.
    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_valid ? w_sel_pix : '0;
    assign bus.m_last     = w_valid && (pix_cnt_q == LAST_IDX);
    assign bus.pix_cnt    = pix_cnt_q;

endmodule : fifo_rd_unpack_32to16
`default_nettype wire

// File: tb/tb_fifo_rd_unpack_32to16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_unpack_32to16
//  Purpose  : Self-checking bench for fifo_rd_unpack_32to16. A queue-based
//             FIFO source and a pixel-queue reference model are advanced once
//             per clock; every cycle the DUT outputs are compared against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_unpack_32to16;

    localparam int LINE = 1920;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_rd_unpack_32to16_if #(
        .RD_DATA_WIDTH (32),
        .PIX_WIDTH     (16),
        .PIX_CNT_W     (11)
    ) bus ();

    fifo_rd_unpack_32to16 #(
        .RD_DATA_WIDTH (32),
        .PIX_WIDTH     (16),
        .LINE_PIXELS   (LINE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs
    bit rst_drv, ready_drv, force_empty;

    // FIFO source and reference model
    logic [31:0] src_q[$];
    int          exp_q[$];
    int          exp_cnt;
    bit          pend_v;
    logic [31:0] pend_w;
    bit          prev_stall;

    // Sampled DUT outputs
    bit s_rd_en, s_valid, s_last, s_empty;
    int s_data, s_pix;

    // Statistics
    int cyc, rd_pulses, beats, lasts, last_beat_idx;
    int first_beat_cyc, last_beat_cyc, first_valid_cyc, first_rd_cyc;
    int log_data[$];
    int log_pix[$];
    int log_cyc[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        rd_pulses = 0; beats = 0; lasts = 0; last_beat_idx = -1;
        first_beat_cyc = -1; last_beat_cyc = -1; first_valid_cyc = -1; first_rd_cyc = -1;
        log_data.delete(); log_pix.delete(); log_cyc.delete();
    endtask

    // One clock cycle: drive inputs after the falling edge, sample and check
    // just before the rising edge, then advance the model.
    task automatic step();
        logic [31:0] w;
        @(negedge clk);
        rst_n = rst_drv;
        if (!rst_drv) begin
            exp_q.delete();
            exp_cnt    = 0;
            pend_v     = 1'b0;
            prev_stall = 1'b0;
        end
        if (pend_v) begin
            bus.fifo_rd_data = pend_w;
            pend_v = 1'b0;
        end
        bus.fifo_rd_empty = force_empty || (src_q.size() == 0);
        bus.m_ready       = ready_drv;
        #3;
        cyc++;
        s_rd_en = bus.fifo_rd_en;
        s_valid = bus.m_valid;
        s_last  = bus.m_last;
        s_empty = bus.fifo_rd_empty;
        s_data  = int'(bus.m_data);
        s_pix   = int'(bus.pix_cnt);

        chk("rd_en_while_empty", s_rd_en && s_empty, 0);

        if (!rst_drv) begin
            chk("rst_rd_en", s_rd_en, 0);
            chk("rst_m_valid", s_valid, 0);
            chk("rst_m_data", s_data, 0);
            chk("rst_m_last", s_last, 0);
            chk("rst_pix_cnt", s_pix, 0);
        end else begin
            if (prev_stall) chk("valid_held_in_stall", s_valid, 1);
            if (s_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_pixel", s_valid, 0);
                end else begin
                    chk("m_data", s_data, exp_q[0]);
                end
                chk("pix_cnt", s_pix, exp_cnt);
                chk("m_last", s_last, (exp_cnt == LINE - 1) ? 1 : 0);
            end else begin
                chk("m_last_idle", s_last, 0);
            end

            if (s_valid && ready_drv) begin
                log_data.push_back(s_data);
                log_pix.push_back(s_pix);
                log_cyc.push_back(cyc);
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                if (s_last) begin
                    lasts++;
                    last_beat_idx = beats;
                end
                beats++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                exp_cnt = (exp_cnt == LINE - 1) ? 0 : exp_cnt + 1;
            end

            if (s_rd_en) begin
                rd_pulses++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (src_q.size() == 0) begin
                    chk("read_without_data", s_rd_en, 0);
                end else begin
                    w = src_q.pop_front();
                    pend_w = w;
                    pend_v = 1'b1;
`ifdef FIFO_RD_UNPACK_HI_FIRST_EN
                    exp_q.push_back(int'(w[31:16]));
                    exp_q.push_back(int'(w[15:0]));
`else
                    exp_q.push_back(int'(w[15:0]));
                    exp_q.push_back(int'(w[31:16]));
`endif
                end
            end
            prev_stall = s_valid && !ready_drv;
        end
    endtask

    task automatic reset_pulse();
        rst_drv = 1'b0;
        src_q.delete();
        step();
        step();
        rst_drv = 1'b1;
    endtask

    int guard, r0, r2, r10;

    initial begin
        rst_n             = 1'b0;
        rst_drv           = 1'b0;
        ready_drv         = 1'b1;
        force_empty       = 1'b0;
        bus.fifo_rd_data  = '0;
        bus.fifo_rd_empty = 1'b1;
        bus.m_ready       = 1'b0;
        exp_cnt = 0; pend_v = 0; pend_w = '0; prev_stall = 0; cyc = 0;
        clear_stats();

        // ---- Reset with a non-empty FIFO, then a single word ----
        src_q.push_back(32'hBBBB_AAAA);
        repeat (3) step();
        rst_drv = 1'b1;
        step();
        chk("release_rd_en", s_rd_en, 1);
        repeat (6) step();
        chk("single_beats", beats, 2);
        chk("single_latency", first_valid_cyc - first_rd_cyc, 2);
        if (beats == 2) begin
`ifdef FIFO_RD_UNPACK_HI_FIRST_EN
            chk("single_pix0", log_data[0], 32'h0000_BBBB);
            chk("single_pix1", log_data[1], 32'h0000_AAAA);
`else
            chk("single_pix0", log_data[0], 32'h0000_AAAA);
            chk("single_pix1", log_data[1], 32'h0000_BBBB);
`endif
            chk("single_back_to_back", log_cyc[1] - log_cyc[0], 1);
        end
        chk("single_rd_pulses", rd_pulses, 1);

        // ---- Full line of 960 incrementing words ----
        reset_pulse();
        clear_stats();
        for (int i = 0; i < 960; i++) src_q.push_back({16'(2 * i + 1), 16'(2 * i)});
        ready_drv = 1'b1;
        guard = 0;
        while (beats < 1920 && guard < 4000) begin
            step();
            guard++;
        end
        chk("line_timeout", (guard < 4000) ? 1 : 0, 1);
        step();
        chk("line_beats", beats, 1920);
        chk("line_last_count", lasts, 1);
        chk("line_last_idx", last_beat_idx, 1919);
        chk("line_no_bubbles", last_beat_cyc - first_beat_cyc, 1919);
        chk("line_rd_pulses", rd_pulses, 960);
        chk("line_pix_wrap", s_pix, 0);
        if (beats == 1920) begin
`ifdef FIFO_RD_UNPACK_HI_FIRST_EN
            chk("line_pix_first", log_data[0], 1);
            chk("line_pix_final", log_data[1919], 1918);
`else
            chk("line_pix_first", log_data[0], 0);
            chk("line_pix_final", log_data[1919], 1919);
`endif
        end

        // ---- Backpressure mid-stream ----
        reset_pulse();
        clear_stats();
        for (int i = 0; i < 100; i++) src_q.push_back(32'h5000_0000 + i);
        ready_drv = 1'b1;
        repeat (20) step();
        ready_drv = 1'b0;
        r0 = rd_pulses;
        repeat (2) step();
        r2 = rd_pulses;
        repeat (8) step();
        r10 = rd_pulses;
        chk("stall_reads_le2", (r10 - r0 <= 2) ? 1 : 0, 1);
        chk("stall_reads_after_fill", r10 - r2, 0);
        chk("stall_valid", s_valid, 1);
        ready_drv = 1'b1;
        guard = 0;
        while (beats < 200 && guard < 1000) begin
            step();
            guard++;
        end
        chk("stall_total_beats", beats, 200);

        // ---- Random ready / empty toggling ----
        reset_pulse();
        clear_stats();
        for (int i = 0; i < 10000; i++) begin
            if (src_q.size() < 4) src_q.push_back($urandom);
            ready_drv   = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 4) == 0);
            step();
        end
        force_empty = 1'b0;
        ready_drv   = 1'b1;
        guard = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || pend_v) && guard < 2000) begin
            step();
            guard++;
        end
        step();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_beats_vs_reads", beats, 2 * rd_pulses);

        // ---- Reset in the middle of a line ----
        reset_pulse();
        clear_stats();
        for (int i = 0; i < 400; i++) src_q.push_back(32'h7000_0000 + i);
        ready_drv = 1'b1;
        guard = 0;
        while (!(s_valid && s_pix == 700) && guard < 2000) begin
            step();
            guard++;
        end
        chk("midline_reached_700", s_pix, 700);
        rst_drv = 1'b0;
        src_q.delete();
        step();
        chk("midline_rst_valid", s_valid, 0);
        chk("midline_rst_pix", s_pix, 0);
        rst_drv = 1'b1;
        clear_stats();
        src_q.push_back(32'h2222_1111);
        repeat (6) step();
        chk("midline_restart_beats", beats, 2);
        if (beats == 2) begin
`ifdef FIFO_RD_UNPACK_HI_FIRST_EN
            chk("midline_restart_pix", log_data[0], 32'h0000_2222);
`else
            chk("midline_restart_pix", log_data[0], 32'h0000_1111);
`endif
            chk("midline_restart_idx", log_pix[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_rd_unpack_32to16
`default_nettype wire

// File: doc/fifo_rd_unpack_32to16.md
# fifo_rd_unpack_32to16

Read-side drain engine for the 16-bit-in/32-bit-out asynchronous line FIFO in the 1080p SFP video path. Pops 32-bit words from the FIFO read port (non-registered output, one-cycle read latency), splits each into two 16-bit pixels and presents them on a valid/ready stream with an end-of-line marker. Lives in the FIFO read clock domain, between the FIFO and the downstream pixel consumer.

## Interface
Parameters:
- RD_DATA_WIDTH, 32, FIFO read word width; must equal 2*PIX_WIDTH
- PIX_WIDTH, 16, output pixel width
- LINE_PIXELS, 1920, pixels per line; drives m_last and pix_cnt wrap

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  FIFO read clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- fifo_rd_en  out  1  FIFO read strobe (combinational)
- fifo_rd_data  in  RD_DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_empty  in  1  FIFO empty flag
- m_data  out  PIX_WIDTH  output pixel
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_last  out  1  high with the last pixel of a line
- pix_cnt  out  11  index of the pixel currently on m_data within the line

## Operation
- 2-entry 32-bit word buffer; occ (0..2) entries held, infl (0..1) reads in flight.
- fifo_rd_en = !fifo_rd_empty && (occ + infl) < 2. Never reads when empty; never overflows buffer.
- infl set on cycle fifo_rd_en=1; next edge pushes fifo_rd_data into buffer, infl clears unless re-issued.
- m_valid = occ != 0. m_data = selected half of head word by half_sel.
- Beat = m_valid && m_ready. On beat: half_sel toggles; when half_sel was 1, head word popped.
- Push and pop on same edge: occ unchanged, data order preserved.
- pix_cnt increments on each beat; wraps LINE_PIXELS-1 -> 0. m_last = m_valid && pix_cnt == LINE_PIXELS-1.
- Odd LINE_PIXELS allowed: line boundary may fall mid-word; half_sel is not reset at line end.
- m_valid held, m_data/m_last stable while m_ready=0 (AXI-stream style, no retraction).
- Reset mid-operation: buffer, infl, half_sel, pix_cnt cleared immediately; pending FIFO data discarded (FIFO reset in same domain).
- Reset values: fifo_rd_en 0 (forced while rst_n=0), m_valid 0, m_data 0, m_last 0, pix_cnt 0.

## Timing
- fifo_rd_en in cycle N -> word in buffer at edge ending N+1 -> m_valid in cycle N+2.
- Empty FIFO to first pixel after a word arrives (empty falls in cycle N): first m_valid in N+2.
- m_ready held 1, FIFO non-empty: one pixel per cycle sustained, fifo_rd_en every other cycle steady-state, no bubbles.
- m_ready low: at most 2 further reads after stall start (buffer fills), then fifo_rd_en stays 0.

## Configuration
- FIFO_RD_UNPACK_HI_FIRST_EN defined: half_sel=0 selects bits [31:16], high pixel first.
- Undefined (default): half_sel=0 selects bits [15:0], low pixel first, matching the FIFO's 16->32 packing order (first-written 16-bit word in low half).

## Structure
- Package fifo_rd_unpack_pkg: RD_DATA_WIDTH, PIX_WIDTH, LINE_PIXELS defaults, PIX_CNT_W = 11, pix_t / word_t typedefs.
- Sub-module fifo_rd_word_buf: 2-entry 32-bit FIFO-ordered buffer with push, pop, occ, head outputs. Top holds read-issue logic, half_sel, pix_cnt.

## Test plan
- Reset: rst_n=0 with fifo_rd_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0, pix_cnt=0; release -> fifo_rd_en=1 next cycle.
- Single word 0xBBBB_AAAA, m_ready=1 -> m_data 0xAAAA then 0xBBBB on consecutive cycles, first m_valid 2 cycles after fifo_rd_en; with FIFO_RD_UNPACK_HI_FIRST_EN order is 0xBBBB, 0xAAAA.
- Stream 960 words (incrementing), m_ready=1 -> 1920 contiguous beats, m_last only on beat 1919, pix_cnt returns to 0, exactly 960 fifo_rd_en pulses.
- Backpressure: m_ready=0 for 10 cycles mid-stream -> exactly ≤2 reads during stall, m_data stable, no pixel lost or duplicated after resume.
- Random m_ready and fifo_rd_empty toggling 10k cycles -> scoreboard order match, fifo_rd_en never high with empty=1, occ never exceeds 2.
- rst_n pulse mid-line (pix_cnt=700) -> all outputs to reset values same cycle; next line restarts at pix_cnt 0, half_sel 0.
